// File: rtl/rram_buf_pkg.sv
// Shared types, default widths and sizing helpers for the RRAM page buffer.
package rram_buf_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_IO_W   = 1;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_SYNC   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOST_WR = 2'd1,
    HOST_RD = 2'd2
  } buf_state_t;

  // Host beats per buffer word.
  function automatic int unsigned beats(input int unsigned data_w, input int unsigned io_w);
    return data_w / io_w;
  endfunction

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// Optional 2-FF synchroniser followed by a registered-history edge detector.
module strobe_sync_edge #(
  parameter int unsigned SYNC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic rise_c,
  output logic fall_c
);

  logic s_c;
  logic s_d_q;

  if (SYNC != 0) begin : g_sync
    logic s1_q;
    logic s2_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= strobe;
        s2_q <= s1_q;
      end
    end
    assign s_c = s2_q;
  end else begin : g_nosync
    assign s_c = strobe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d_q <= 1'b0;
    else        s_d_q <= s_c;
  end

  assign rise_c = s_c & ~s_d_q;
  assign fall_c = ~s_c & s_d_q;

endmodule

// File: rtl/rram_page_buffer.sv
// Page buffer between narrow host IO beats and the RRAM array engines.
module rram_page_buffer
  import rram_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IO_W   = DEF_IO_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned SYNC   = DEF_SYNC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     cle,
  input  logic                     ale,
  input  logic                     we,
  input  logic                     re,
  input  logic                     ctrl_we,
  input  logic                     ctrl_re,
  input  logic                     col_ld,
  input  logic [$clog2(DEPTH)-1:0] col_addr,
  input  logic [IO_W-1:0]          io_in,
  output logic [IO_W-1:0]          io_out,
  output logic                     io_oe,
  input  logic [$clog2(DEPTH)-1:0] arr_addr,
  input  logic                     arr_we,
  input  logic [DATA_W-1:0]        arr_wdata,
  output logic [DATA_W-1:0]        arr_rdata,
  output logic [$clog2(DEPTH):0]   word_cnt,
  output logic                     buf_full,
  output logic                     ovf_err
);

  localparam int unsigned BEATS = beats(DATA_W, IO_W);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned BW    = cnt_w(BEATS);

  buf_state_t        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     word_cnt_d;
  logic              buf_full_d, ovf_err_d, io_oe_d;
  logic [IO_W-1:0]   io_out_d;
  logic              host_commit_c;
  logic              wr_beat_c, rd_beat_c;
  logic              we_rise_c, we_fall_c, re_rise_c, re_fall_c;
  logic [DATA_W-1:0] rd_word_c;

  logic [DATA_W-1:0] mem [DEPTH];

  strobe_sync_edge #(.SYNC(SYNC)) u_we_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (we),
    .rise_c (we_rise_c),
    .fall_c (we_fall_c)
  );

  strobe_sync_edge #(.SYNC(SYNC)) u_re_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (re),
    .rise_c (re_rise_c),
    .fall_c (re_fall_c)
  );

  // Only the write-strobe rise and read-strobe fall carry meaning.
  logic unused_edges_c;
  assign unused_edges_c = we_fall_c | re_rise_c;

  assign arr_rdata = mem[arr_addr];
  assign rd_word_c = mem[rd_ptr_q];

  // Next-state logic; ce and conflicting controller modes both force IDLE.
  always_comb begin
    state_d = state_q;
    if (ce || (ctrl_we && ctrl_re)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ctrl_we)      state_d = HOST_WR;
          else if (ctrl_re) state_d = HOST_RD;
        end
        HOST_WR: if (!ctrl_we) state_d = IDLE;
        HOST_RD: if (!ctrl_re) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign wr_beat_c = (state_q == HOST_WR) && ctrl_we && !ctrl_re && we_rise_c && !cle && !ale;
  assign rd_beat_c = (state_q == HOST_RD) && ctrl_re && !ctrl_we && re_fall_c;

  // Datapath next values; priority is ce, then col_ld, then beats.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    shift_d       = shift_q;
    word_cnt_d    = word_cnt;
    ovf_err_d     = ovf_err;
    io_out_d      = io_out;
    io_oe_d       = (state_q == HOST_RD) && !ce;
    host_commit_c = 1'b0;
    if (ce) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      beat_cnt_d = '0;
      shift_d    = '0;
      word_cnt_d = '0;
      ovf_err_d  = 1'b0;
      io_out_d   = '0;
    end else begin
      if (col_ld) begin
        wr_ptr_d   = col_addr;
        rd_ptr_d   = col_addr;
        beat_cnt_d = '0;
      end else if (wr_beat_c) begin
        if (buf_full) begin
          ovf_err_d = 1'b1;
        end else begin
          shift_d = {io_in, shift_q[DATA_W-1:IO_W]};
          if (beat_cnt_q == BW'(BEATS - 1)) begin
            host_commit_c = 1'b1;
            wr_ptr_d      = wr_ptr_q + AW'(1);
            word_cnt_d    = word_cnt + CW'(1);
            beat_cnt_d    = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end else if (rd_beat_c) begin
        io_out_d = rd_word_c[32'(beat_cnt_q) * IO_W +: IO_W];
        if (beat_cnt_q == BW'(BEATS - 1)) begin
          rd_ptr_d   = rd_ptr_q + AW'(1);
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      // Leaving write mode discards any partially assembled word.
      if (state_q == HOST_WR && state_d != HOST_WR) begin
        beat_cnt_d = '0;
        shift_d    = '0;
      end
    end
    buf_full_d = (word_cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      shift_q    <= '0;
      word_cnt   <= '0;
      buf_full   <= 1'b0;
      ovf_err    <= 1'b0;
      io_out     <= '0;
      io_oe      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
      word_cnt   <= word_cnt_d;
      buf_full   <= buf_full_d;
      ovf_err    <= ovf_err_d;
      io_out     <= io_out_d;
      io_oe      <= io_oe_d;
    end
  end

  // Storage keeps its contents across reset and ce; the array port is locked out during host writes.
  always_ff @(posedge clk) begin
    if (host_commit_c)
      mem[wr_ptr_q] <= shift_d;
    else if (arr_we && state_q != HOST_WR)
      mem[arr_addr] <= arr_wdata;
  end

endmodule

// File: tb/tb_rram_page_buffer.sv
// Directed self-checking bench for rram_page_buffer with byte-wide host IO.
module tb_rram_page_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IO_W   = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n, ce, cle, ale, we, re, ctrl_we, ctrl_re, col_ld, arr_we;
  logic [AW-1:0]     col_addr, arr_addr;
  logic [IO_W-1:0]   io_in, io_out;
  logic              io_oe, buf_full, ovf_err;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic [AW:0]       word_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  rram_page_buffer #(.DATA_W(DATA_W), .IO_W(IO_W), .DEPTH(DEPTH), .SYNC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .cle(cle), .ale(ale), .we(we), .re(re),
    .ctrl_we(ctrl_we), .ctrl_re(ctrl_re), .col_ld(col_ld), .col_addr(col_addr),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .arr_addr(arr_addr),
    .arr_we(arr_we), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata),
    .word_cnt(word_cnt), .buf_full(buf_full), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic we_beat(input logic [7:0] b);
    io_in = b;
    we = 1'b1;
    tick(4);
    we = 1'b0;
    tick(4);
  endtask

  task automatic write_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) we_beat(w[8*k +: 8]);
  endtask

  task automatic re_beat(input string tag, input logic [7:0] exp);
    re = 1'b0;
    tick(4);
    chk(tag, 32'(io_out), 32'(exp));
    re = 1'b1;
    tick(4);
  endtask

  task automatic load_col(input logic [AW-1:0] a);
    col_addr = a;
    col_ld = 1'b1;
    tick(1);
    col_ld = 1'b0;
  endtask

  function automatic logic [31:0] fill_word(input int i);
    return {8'(i), 8'h5A, 8'hC3, 8'(i)};
  endfunction

  initial begin
    rst_n = 1'b0; ce = 1'b0; cle = 1'b0; ale = 1'b0; we = 1'b0; re = 1'b1;
    ctrl_we = 1'b0; ctrl_re = 1'b0; col_ld = 1'b0; col_addr = '0;
    io_in = '0; arr_addr = '0; arr_we = 1'b0; arr_wdata = '0;
    tick(3);
    chk("rst_io_out", 32'(io_out), 32'h0);
    chk("rst_io_oe", 32'(io_oe), 32'h0);
    chk("rst_word_cnt", 32'(word_cnt), 32'h0);
    chk("rst_buf_full", 32'(buf_full), 32'h0);
    chk("rst_ovf_err", 32'(ovf_err), 32'h0);
    rst_n = 1'b1;
    tick(4);

    // First word assembled LSB-first into mem[0].
    load_col(3'd0);
    ctrl_we = 1'b1;
    tick(2);
    we_beat(8'h0F); we_beat(8'h0F); we_beat(8'hA5);
    chk("partial_word_cnt", 32'(word_cnt), 32'h0);
    we_beat(8'hA5);
    arr_addr = 3'd0;
    #1 chk("wr_word0", arr_rdata, 32'hA5A5_0F0F);
    chk("wr_word_cnt", 32'(word_cnt), 32'h1);

    // Fill the rest, then overflow with one extra beat.
    for (int i = 1; i < 8; i++) write_word(fill_word(i));
    chk("full_word_cnt", 32'(word_cnt), 32'h8);
    chk("full_flag", 32'(buf_full), 32'h1);
    chk("full_no_ovf", 32'(ovf_err), 32'h0);
    arr_addr = 3'd7;
    #1 chk("full_word7", arr_rdata, 32'h075A_C307);
    we_beat(8'hFF);
    chk("ovf_set", 32'(ovf_err), 32'h1);
    chk("ovf_word_cnt", 32'(word_cnt), 32'h8);
    arr_addr = 3'd0;
    #1 chk("ovf_word0_kept", arr_rdata, 32'hA5A5_0F0F);

    ctrl_we = 1'b0;
    tick(2);
    ce = 1'b1;
    tick(1);
    ce = 1'b0;
    chk("ce_ovf_clr", 32'(ovf_err), 32'h0);
    chk("ce_cnt_clr", 32'(word_cnt), 32'h0);
    chk("ce_full_clr", 32'(buf_full), 32'h0);
    arr_addr = 3'd3;
    #1 chk("ce_data_kept", arr_rdata, 32'h035A_C303);

    // Array loads two words, host reads across the wrap point.
    tick(1);
    arr_we = 1'b1; arr_addr = 3'd7; arr_wdata = 32'h1122_3344;
    tick(1);
    arr_addr = 3'd0; arr_wdata = 32'h5566_7788;
    tick(1);
    arr_we = 1'b0;
    load_col(3'd7);
    ctrl_re = 1'b1;
    tick(3);
    chk("rd_io_oe", 32'(io_oe), 32'h1);
    re_beat("rd_b0", 8'h44); re_beat("rd_b1", 8'h33);
    re_beat("rd_b2", 8'h22); re_beat("rd_b3", 8'h11);
    re_beat("rd_b4", 8'h88); re_beat("rd_b5", 8'h77);
    re_beat("rd_b6", 8'h66); re_beat("rd_b7", 8'h55);
    chk("rd_io_oe_end", 32'(io_oe), 32'h1);

    // Conflicting modes: IDLE, pad disabled, read beats ignored.
    ctrl_we = 1'b1;
    tick(3);
    chk("both_io_oe", 32'(io_oe), 32'h0);
    re_beat("both_no_beat", 8'h55);
    ctrl_we = 1'b0;
    tick(3);
    re_beat("rd_resume", 8'h01);
    ctrl_re = 1'b0;
    tick(2);

    // Aborted write: partial beats are discarded and wr_ptr holds.
    load_col(3'd2);
    ctrl_we = 1'b1;
    tick(2);
    we_beat(8'hAA); we_beat(8'hBB);
    ctrl_we = 1'b0;
    tick(2);
    ctrl_we = 1'b1;
    tick(2);
    write_word(32'hDEAD_BEEF);
    arr_addr = 3'd2;
    #1 chk("abort_word2", arr_rdata, 32'hDEAD_BEEF);
    arr_addr = 3'd3;
    #1 chk("abort_word3_kept", arr_rdata, 32'h035A_C303);
    chk("abort_word_cnt", 32'(word_cnt), 32'h1);

    // ale beats are ignored; array writes are locked out during host write.
    ale = 1'b1;
    we_beat(8'h99);
    ale = 1'b0;
    arr_addr = 3'd5; arr_wdata = 32'hFFFF_FFFF; arr_we = 1'b1;
    tick(1);
    arr_we = 1'b0;
    #1 chk("arr_we_blocked", arr_rdata, 32'h055A_C305);
    write_word(32'hCAFE_F00D);
    arr_addr = 3'd3;
    #1 chk("ale_ignored", arr_rdata, 32'hCAFE_F00D);
    chk("ale_word_cnt", 32'(word_cnt), 32'h2);

    // Asynchronous reset in the middle of a read.
    ctrl_we = 1'b0;
    tick(2);
    load_col(3'd3);
    ctrl_re = 1'b1;
    tick(3);
    re_beat("mid_b0", 8'h0D); re_beat("mid_b1", 8'hF0); re_beat("mid_b2", 8'hFE);
    #1 rst_n = 1'b0;
    #1 chk("arst_io_out", 32'(io_out), 32'h0);
    chk("arst_io_oe", 32'(io_oe), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    re_beat("arst_rd_ptr0", 8'h88);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rram_page_buffer.md
Name: rram_page_buffer

Overview:
- Parametrised page buffer between the serial/narrow host IO pins and the RRAM read/program engines.
- Host write beats (WE strobe) are assembled LSB-first into DATA_W words and stored in a DEPTH-word buffer.
- Host read beats (RE strobe) are driven out from any starting word.
- The array side writes read-back data into, and reads program data out of, the same buffer. Fully synchronous; strobes are synchronised and edge-detected.

Parameters:
- DATA_W, 32, word width; must be a multiple of IO_W.
- IO_W, 1, host IO beat width (1 or 8).
- DEPTH, 8, buffer depth in words (power of 2, at least 2).
- SYNC, 1, 1 = 2-FF synchroniser on we/re; 0 = strobes already in clk domain.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ce  in  1  chip deselect, high = inactive; clears pointers/flags.
- cle  in  1  command latch enable; beats ignored when high.
- ale  in  1  address latch enable; beats ignored when high.
- we  in  1  host write strobe; beat captured on rising edge.
- re  in  1  host read strobe; beat driven on falling edge.
- ctrl_we  in  1  controller write-mode enable.
- ctrl_re  in  1  controller read-mode enable.
- col_ld  in  1  one-cycle pulse: load column start.
- col_addr  in  $clog2(DEPTH)  start word for reads/writes.
- io_in  in  IO_W  host beat in.
- io_out  out  IO_W  host beat out.
- io_oe  out  1  pad output enable.
- arr_addr  in  $clog2(DEPTH)  array-side word address.
- arr_we  in  1  array-side word write.
- arr_wdata  in  DATA_W  array-side write data.
- arr_rdata  out  DATA_W  mem[arr_addr], combinational.
- word_cnt  out  $clog2(DEPTH)+1  host words committed.
- buf_full  out  1  word_cnt == DEPTH.
- ovf_err  out  1  sticky: write beat while full.

Behaviour:
- BEATS = DATA_W/IO_W.
- Strobe path: we/re pass through a 2-FF sync (SYNC=1), then a registered edge detect.
  - we-rise to beat capture: 3 clk (SYNC=1), 1 clk (SYNC=0).
  - re-fall to io_out valid: same latency.
- Reset (rst_n low) values:
  - io_out=0, io_oe=0, word_cnt=0, buf_full=0, ovf_err=0.
  - Pointers, beat counter and shift register = 0; state=IDLE.
  - Memory contents undefined.
- ce high: synchronous clear of everything cleared by reset except memory, which is retained. State forced to IDLE. Has priority over all other events.
- FSM states: IDLE, HOST_WR, HOST_RD.
  - IDLE→HOST_WR: ctrl_we & !ctrl_re & !ce.
  - IDLE→HOST_RD: ctrl_re & !ctrl_we & !ce.
  - ctrl_we & ctrl_re both high: stay/return IDLE, no beat action.
  - HOST_WR→IDLE: ctrl_we low. Partial word discarded, beat_cnt=0, wr_ptr kept.
  - HOST_RD→IDLE: ctrl_re low. rd_ptr and beat_cnt kept, so reads resume.
- col_ld (any state): wr_ptr=rd_ptr=col_addr, beat_cnt=0. word_cnt is not changed.
- HOST_WR beat (we_rise & !cle & !ale):
  - shift <= {io_in, shift[DATA_W-1:IO_W]}; beat_cnt++.
  - On beat BEATS-1: mem[wr_ptr] <= assembled word, wr_ptr++ (wraps mod DEPTH), word_cnt++, beat_cnt=0.
  - If buf_full when a beat arrives: beat dropped, ovf_err=1 until ce or reset.
  - Beats with cle or ale high: ignored entirely.
- HOST_RD beat (re_fall):
  - io_out <= mem[rd_ptr][beat_cnt*IO_W +: IO_W]; beat_cnt++.
  - On last beat: rd_ptr++ (wraps DEPTH-1→0), beat_cnt=0.
- io_oe = (state==HOST_RD) & !ce, registered (1 clk after state entry).
- Array side:
  - arr_we writes mem[arr_addr] at clk edge only when state != HOST_WR.
  - arr_we is ignored in HOST_WR; the controller guarantees exclusion.
  - arr_rdata is always combinational mem[arr_addr].
  - Host read of a word written by arr_we in the previous cycle returns the new data.

Decomposition:
- Package rram_buf_pkg holds:
  - state enum buf_state_t (IDLE, HOST_WR, HOST_RD);
  - function beats(DATA_W, IO_W);
  - localparam default widths.
- Sub-module strobe_sync_edge (SYNC param, outputs rise/fall pulses), instantiated for we and re.
- Storage is a plain register array; no RAM macro.

Test Plan:
- Write, DATA_W=32 IO_W=1: col_ld col_addr=0; ctrl_we=1; 32 we beats of 0xA5A5_0F0F LSB-first → arr_addr=0 gives arr_rdata=0xA5A5_0F0F, word_cnt=1.
- Full: DEPTH=8, 8 full words then 1 extra beat → buf_full=1, ovf_err=1, mem[0..7] unchanged, word_cnt=8; ce pulse → ovf_err=0, word_cnt=0, data retained.
- Read wrap, IO_W=8:
  - arr_we loads mem[7]=0x11223344 and mem[0]=0x55667788; col_addr=7; ctrl_re=1.
  - 8 re beats → io_out = 44,33,22,11,88,77,66,55; io_oe=1 throughout.
- Abort: ctrl_we low after 10 beats → next word starts fresh; earlier partial beats absent from mem; wr_ptr unchanged.
- Ignores:
  - we beats with ale=1 → no shift, no beat_cnt change;
  - ctrl_we=ctrl_re=1 → state IDLE, io_oe=0.
- Reset mid-read: rst_n low after 3 beats → io_out=0, io_oe=0 immediately (asynchronous); after release rd_ptr=0.
